// File: rtl/encoder_8to3_pend.sv
// encoder_8to3_pend: pending-request register feeding a registered priority encoder with valid/ready output
module encoder_8to3_pend #(
  parameter int N       = 8,
  parameter int W       = 3,
  parameter bit PRIO_HI = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  input  logic         clr,
  output logic [W-1:0] out,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         err
);
  logic [W-1:0] idx;
  logic [N-1:0] pop;
  logic         load;
  assign load = |pending && (!valid || ready);
  // later iterations overwrite earlier ones, so scan order sets the winner
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++)
      if (pending[PRIO_HI ? i : N-1-i]) idx = W'(PRIO_HI ? i : N-1-i);
  end
  assign pop = load ? (N'(1) << idx) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      out     <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else if (clr) begin
      pending <= '0;
      out     <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      pending <= (pending & ~pop) | in;
      err     <= |(in & pending & ~pop);
      if (load) begin
        out   <= idx;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule
